mips_out_capture: RTL and testbench

- Consumer-side companion to the `mips` core's observation outputs `out1`/`out2`.
- Samples both 32-bit buses every clock and detects any change against the previous cycle's values.
- On a change, pushes the value pair plus a cycle timestamp into an internal FIFO.
- Exposes the FIFO through a valid/ready read port, so a debug host or bench reads results as a stream instead of probing waveforms.

---
 rtl/mips_out_capture_if.sv | 30 +++
 rtl/mips_out_capture.sv | 99 +++++++++
 tb/tb_mips_out_capture.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_out_capture_if.sv
// Bundle of observed buses, capture control and FIFO read port for mips_out_capture.
// The slave side is the capture block; the master side is the bench or debug host.
interface mips_out_capture_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CYC_W  = 16
);
    logic [DATA_W-1:0]       in1;
    logic [DATA_W-1:0]       in2;
    logic                    capture_en;
    logic                    rd_ready;
    logic                    rd_valid;
    logic [DATA_W-1:0]       rd_out1;
    logic [DATA_W-1:0]       rd_out2;
    logic [CYC_W-1:0]        rd_cycle;
    logic [$clog2(DEPTH):0]  count;
    logic                    full;
    logic                    overflow;
    logic [7:0]              drop_cnt;

    modport master (
        output in1, in2, capture_en, rd_ready,
        input  rd_valid, rd_out1, rd_out2, rd_cycle, count, full, overflow, drop_cnt
    );

    modport slave (
        input  in1, in2, capture_en, rd_ready,
        output rd_valid, rd_out1, rd_out2, rd_cycle, count, full, overflow, drop_cnt
    );
endinterface

// File: rtl/mips_out_capture.sv
// Watches two observation buses, queues every change with a cycle timestamp,
// and presents the queue as a first-word-fall-through valid/ready stream.
module mips_out_capture #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CYC_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_out_capture_if.slave    cap
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 2 * DATA_W + CYC_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] prev1_q, prev1_d;
    logic [DATA_W-1:0] prev2_q, prev2_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [ENT_W-1:0]  wr_data;
    logic [ENT_W-1:0]  head;

    logic chg, push_req, pop, push_ok, drop, is_full, is_valid;

    always_comb begin
        chg        = (cap.in1 != prev1_q) || (cap.in2 != prev2_q);
        push_req   = cap.capture_en && chg;
        is_valid   = (count_q != '0);
        is_full    = (count_q == CNT_FULL);
        pop        = is_valid && cap.rd_ready;
        // A full FIFO still takes the new entry when the head leaves this cycle.
        push_ok    = push_req && (!is_full || pop);
        drop       = push_req && is_full && !pop;
        wr_data    = {cap.in1, cap.in2, cyc_q};

        prev1_d    = cap.in1;
        prev2_d    = cap.in2;
        cyc_d      = cyc_q + 1'b1;
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q | drop;
        drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev1_q    <= '0;
            prev2_q    <= '0;
            cyc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            prev1_q    <= prev1_d;
            prev2_q    <= prev2_d;
            cyc_q      <= cyc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; the read port masks it to zero whenever empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        head = mem_q[rd_ptr_q];
    end

    assign cap.rd_valid = is_valid;
    assign cap.rd_out1  = is_valid ? head[ENT_W-1 -: DATA_W] : '0;
    assign cap.rd_out2  = is_valid ? head[CYC_W +: DATA_W]   : '0;
    assign cap.rd_cycle = is_valid ? head[CYC_W-1:0]         : '0;
    assign cap.count    = count_q;
    assign cap.full     = is_full;
    assign cap.overflow = overflow_q;
    assign cap.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_mips_out_capture.sv
// Randomized and directed bench for mips_out_capture against a queue-based model.
module tb_mips_out_capture;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CYC_W  = 16;

    typedef struct packed {
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [CYC_W-1:0]  c;
    } ent_t;

    logic clk;
    logic rst;

    mips_out_capture_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CYC_W(CYC_W)) cap_if ();

    mips_out_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
        .clk (clk),
        .rst (rst),
        .cap (cap_if.slave)
    );

    int checks = 0;
    int errors = 0;

    ent_t              mq[$];
    logic [DATA_W-1:0] m_prev1, m_prev2;
    logic [CYC_W-1:0]  m_cyc;
    logic              m_ovf;
    int                m_drop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_prev1 = '0;
        m_prev2 = '0;
        m_cyc   = '0;
        m_ovf   = 1'b0;
        m_drop  = 0;
    endtask

    // What one rising edge does, stated as queue operations.
    task automatic model_step();
        bit chg, push_req, pop, was_full;
        if (rst) begin
            model_reset();
            return;
        end
        chg      = (cap_if.in1 != m_prev1) || (cap_if.in2 != m_prev2);
        push_req = cap_if.capture_en && chg;
        was_full = (mq.size() == DEPTH);
        pop      = (mq.size() != 0) && cap_if.rd_ready;
        if (pop) void'(mq.pop_front());
        if (push_req) begin
            if (!was_full || pop) mq.push_back({cap_if.in1, cap_if.in2, m_cyc});
            else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        m_prev1 = cap_if.in1;
        m_prev2 = cap_if.in2;
        m_cyc   = m_cyc + 1'b1;
    endtask

    always @(negedge clk) begin
        chk("rd_valid", 64'(cap_if.rd_valid), 64'(mq.size() != 0));
        chk("count", 64'(cap_if.count), 64'(mq.size()));
        chk("full", 64'(cap_if.full), 64'(mq.size() == DEPTH));
        chk("overflow", 64'(cap_if.overflow), 64'(m_ovf));
        chk("drop_cnt", 64'(cap_if.drop_cnt), 64'(m_drop));
        if (mq.size() != 0) begin
            chk("rd_out1", 64'(cap_if.rd_out1), 64'(mq[0].d1));
            chk("rd_out2", 64'(cap_if.rd_out2), 64'(mq[0].d2));
            chk("rd_cycle", 64'(cap_if.rd_cycle), 64'(mq[0].c));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic async_reset(input int hold);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_rd_valid", 64'(cap_if.rd_valid), 64'd0);
        chk("rst_count", 64'(cap_if.count), 64'd0);
        chk("rst_overflow", 64'(cap_if.overflow), 64'd0);
        chk("rst_drop_cnt", 64'(cap_if.drop_cnt), 64'd0);
        repeat (hold) tick();
        rst = 1'b0;
    endtask

    initial begin
        int rdy_pct;
        model_reset();
        rst               = 1'b1;
        cap_if.in1        = '0;
        cap_if.in2        = '0;
        cap_if.capture_en = 1'b1;
        cap_if.rd_ready   = 1'b0;

        // Reset and idle
        repeat (10) tick();
        chk("idle_valid", 64'(cap_if.rd_valid), 64'd0);
        chk("idle_count", 64'(cap_if.count), 64'd0);
        rst = 1'b0;

        // Single change timestamped at counter = 3
        while (m_cyc != 3) tick();
        cap_if.in1 = 32'd5;
        #1;
        chk("no_bypass", 64'(cap_if.rd_valid), 64'd0);
        tick();
        chk("single_valid", 64'(cap_if.rd_valid), 64'd1);
        chk("single_out1", 64'(cap_if.rd_out1), 64'd5);
        chk("single_out2", 64'(cap_if.rd_out2), 64'd0);
        chk("single_cycle", 64'(cap_if.rd_cycle), 64'd3);
        cap_if.rd_ready = 1'b1;
        tick();
        cap_if.rd_ready = 1'b0;
        chk("pop_valid", 64'(cap_if.rd_valid), 64'd0);
        chk("pop_count", 64'(cap_if.count), 64'd0);

        // capture_en gating
        cap_if.capture_en = 1'b0;
        cap_if.in2        = 32'hDEAD_BEEF;
        tick();
        cap_if.capture_en = 1'b1;
        tick();
        chk("gated_count", 64'(cap_if.count), 64'd0);

        // Fill and overflow, then drain in order
        for (int i = 1; i <= 20; i++) begin
            cap_if.in1 = 32'(i);
            tick();
        end
        chk("fill_count", 64'(cap_if.count), 64'd16);
        chk("fill_full", 64'(cap_if.full), 64'd1);
        chk("fill_overflow", 64'(cap_if.overflow), 64'd1);
        chk("fill_drop", 64'(cap_if.drop_cnt), 64'd4);
        cap_if.rd_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_order", 64'(cap_if.rd_out1), 64'(i));
            tick();
        end
        cap_if.rd_ready = 1'b0;
        chk("drain_count", 64'(cap_if.count), 64'd0);

        // Full with simultaneous push and pop
        for (int i = 201; i <= 216; i++) begin
            cap_if.in1 = 32'(i);
            tick();
        end
        cap_if.in1      = 32'd300;
        cap_if.rd_ready = 1'b1;
        tick();
        chk("pp_count", 64'(cap_if.count), 64'd16);
        chk("pp_drop", 64'(cap_if.drop_cnt), 64'd4);
        for (int i = 0; i < 16; i++) begin
            chk("pp_order", 64'(cap_if.rd_out1), (i < 15) ? 64'(202 + i) : 64'd300);
            tick();
        end

        // drop_cnt saturation
        cap_if.rd_ready = 1'b0;
        for (int i = 0; i < 280; i++) begin
            cap_if.in1 = 32'(1000 + i);
            tick();
        end
        chk("sat_drop", 64'(cap_if.drop_cnt), 64'd255);

        // Reset mid-operation at count = 5
        cap_if.rd_ready = 1'b1;
        repeat (11) tick();
        cap_if.rd_ready = 1'b0;
        chk("pre_rst_count", 64'(cap_if.count), 64'd5);
        async_reset(2);
        tick();
        chk("post_rst_valid", 64'(cap_if.rd_valid), 64'd1);
        chk("post_rst_cycle", 64'(cap_if.rd_cycle), 64'd0);
        chk("post_rst_out1", 64'(cap_if.rd_out1), 64'd1279);

        // Randomized traffic
        rdy_pct = 80;
        for (int n = 0; n < 4000; n++) begin
            if (n % 300 == 0) rdy_pct = (rdy_pct == 80) ? 15 : 80;
            if ($urandom_range(0, 2) == 0) cap_if.in1 = 32'($urandom_range(0, 3)) * 32'h1111_1111;
            if ($urandom_range(0, 3) == 0) cap_if.in2 = $urandom;
            cap_if.capture_en = ($urandom_range(0, 9) != 0);
            cap_if.rd_ready   = ($urandom_range(0, 99) < rdy_pct);
            if (n % 997 == 500) async_reset($urandom_range(0, 2));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
